// File: rtl/ram_bank_pkg.sv
// ram_bank shared definitions:
// FSM state encoding and requester ids.
package ram_bank_pkg;

  typedef enum logic [1:0] {
    ST_INIT,
    ST_IDLE,
    ST_WAIT,
    ST_ACK
  } state_e;

  localparam logic PORT_D = 1'b0;
  localparam logic PORT_I = 1'b1;

endpackage

// File: rtl/ram_bank_array.sv
// Single-port word storage:
// byte-enabled synchronous write, asynchronous read.
module ram_array #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 8
) (
  input  logic                clk_i,
  input  logic                we_i,
  input  logic [ADDR_W-1:0]   addr_i,
  input  logic [DATA_W-1:0]   wdata_i,
  input  logic [DATA_W/8-1:0] be_i,
  output logic [DATA_W-1:0]   rdata_o
);

  localparam int unsigned BW = DATA_W / 8;

  logic [DATA_W-1:0] mem_q [2**ADDR_W];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int k = 0; k < BW; k++) begin
        if (be_i[k]) begin
          mem_q[addr_i][8*k +: 8] <= wdata_i[8*k +: 8];
        end
      end
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/ram_bank.sv
// Two-requester RAM bank: data and fetch ports
// share one array via a fair arbiter and wait FSM.
module ram_bank
  import ram_bank_pkg::*;
#(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned WAIT       = 1,
  parameter int unsigned INIT_CLEAR = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_be,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_ack,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic [DATA_W-1:0]   i_rdata,
  output logic                i_ack,
  output logic                ready
);

  localparam int unsigned BW = DATA_W / 8;
  localparam logic [ADDR_W:0] CLR_ONE = 1;

  state_e              state_q, state_d;
  logic [ADDR_W:0]     clr_q, clr_d;
  logic [2:0]          cnt_q, cnt_d;
  logic                last_q, last_d;
  logic                port_q, port_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [BW-1:0]       be_q, be_d;
  logic [DATA_W-1:0]   drd_q, drd_d;
  logic [DATA_W-1:0]   ird_q, ird_d;

  logic                gnt;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_wdata;
  logic [BW-1:0]       mem_be;
  logic [DATA_W-1:0]   mem_rdata;

  always_comb begin
    state_d   = state_q;
    clr_d     = clr_q;
    cnt_d     = cnt_q;
    last_d    = last_q;
    port_d    = port_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    be_d      = be_q;
    drd_d     = drd_q;
    ird_d     = ird_q;
    gnt       = PORT_D;
    mem_we    = 1'b0;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    mem_be    = be_q;
    d_ack     = 1'b0;
    i_ack     = 1'b0;
    d_rdata   = drd_q;
    i_rdata   = ird_q;
    ready     = 1'b1;
    unique case (state_q)
      ST_INIT: begin
        ready = 1'b0;
        if (INIT_CLEAR != 0 && !clr_q[ADDR_W]) begin
          mem_we    = 1'b1;
          mem_addr  = clr_q[ADDR_W-1:0];
          mem_wdata = '0;
          mem_be    = '1;
          clr_d     = clr_q + CLR_ONE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (d_req || i_req) begin
          // on a tie, the port not served last wins
          gnt = (d_req && (!i_req || last_q == PORT_I))
              ? PORT_D : PORT_I;
          port_d = gnt;
          last_d = gnt;
          if (gnt == PORT_D) begin
            we_d    = d_we;
            addr_d  = d_addr;
            wdata_d = d_wdata;
            be_d    = d_be;
          end else begin
            we_d    = 1'b0;
            addr_d  = i_addr;
          end
          cnt_d   = 3'(WAIT);
          state_d = (WAIT == 0) ? ST_ACK : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q <= 3'd1) begin
          cnt_d   = 3'd0;
          state_d = ST_ACK;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      ST_ACK: begin
        state_d = ST_IDLE;
        mem_we  = we_q;
        if (port_q == PORT_D) begin
          d_ack = 1'b1;
          if (!we_q) begin
            d_rdata = mem_rdata;
            drd_d   = mem_rdata;
          end
        end else begin
          i_ack   = 1'b1;
          i_rdata = mem_rdata;
          ird_d   = mem_rdata;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_INIT;
      clr_q   <= '0;
      cnt_q   <= '0;
      last_q  <= PORT_I;
      port_q  <= PORT_D;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      drd_q   <= '0;
      ird_q   <= '0;
    end else begin
      state_q <= state_d;
      clr_q   <= clr_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      port_q  <= port_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      drd_q   <= drd_d;
      ird_q   <= ird_d;
    end
  end

  // reset must block any array write on the edge it overlaps
  ram_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk_i   (clk),
    .we_i    (mem_we & ~rst),
    .addr_i  (mem_addr),
    .wdata_i (mem_wdata),
    .be_i    (mem_be),
    .rdata_o (mem_rdata)
  );

endmodule

// File: tb/tb_ram_bank.sv
// Randomized bench for ram_bank: two instances
// (WAIT=2 with clear, WAIT=0 without) vs. an array model.
module tb_ram_bank;

  logic        clk = 1'b0;
  logic        rst     [2];
  logic        d_req   [2];
  logic        d_we    [2];
  logic [7:0]  d_addr  [2];
  logic [15:0] d_wdata [2];
  logic [1:0]  d_be    [2];
  logic [15:0] d_rdata [2];
  logic        d_ack   [2];
  logic        i_req   [2];
  logic [7:0]  i_addr  [2];
  logic [15:0] i_rdata [2];
  logic        i_ack   [2];
  logic        ready   [2];

  int n_run  = 0;
  int n_fail = 0;

  logic [15:0] mem   [2][256];
  int          wt    [2] = '{2, 0};
  bit          clr   [2] = '{1'b1, 1'b0};
  bit          lastg [2];
  logic [15:0] lastd [2];
  logic [15:0] lasti [2];

  always #5 clk = ~clk;

  ram_bank #(
    .DATA_W(16), .ADDR_W(8), .WAIT(2), .INIT_CLEAR(1)
  ) u_dut0 (
    .clk(clk), .rst(rst[0]),
    .d_req(d_req[0]), .d_we(d_we[0]), .d_addr(d_addr[0]),
    .d_wdata(d_wdata[0]), .d_be(d_be[0]),
    .d_rdata(d_rdata[0]), .d_ack(d_ack[0]),
    .i_req(i_req[0]), .i_addr(i_addr[0]),
    .i_rdata(i_rdata[0]), .i_ack(i_ack[0]),
    .ready(ready[0])
  );

  ram_bank #(
    .DATA_W(16), .ADDR_W(8), .WAIT(0), .INIT_CLEAR(0)
  ) u_dut1 (
    .clk(clk), .rst(rst[1]),
    .d_req(d_req[1]), .d_we(d_we[1]), .d_addr(d_addr[1]),
    .d_wdata(d_wdata[1]), .d_be(d_be[1]),
    .d_rdata(d_rdata[1]), .d_ack(d_ack[1]),
    .i_req(i_req[1]), .i_addr(i_addr[1]),
    .i_rdata(i_rdata[1]), .i_ack(i_ack[1]),
    .ready(ready[1])
  );

  task automatic check(string tag, logic [31:0] got,
                       logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(int u);
    int n;
    rst[u]   = 1'b1;
    d_req[u] = 1'b0;
    i_req[u] = 1'b0;
    #2;
    check("rst_ready", 32'(ready[u]), 0);
    check("rst_d_ack", 32'(d_ack[u]), 0);
    check("rst_i_ack", 32'(i_ack[u]), 0);
    check("rst_d_rdata", 32'(d_rdata[u]), 0);
    check("rst_i_rdata", 32'(i_rdata[u]), 0);
    cyc();
    rst[u] = 1'b0;
    n = 0;
    while (!ready[u] && n < 600) begin
      cyc();
      n++;
    end
    check("ready_latency", n, clr[u] ? 257 : 1);
    lastg[u] = 1'b1;
    lastd[u] = '0;
    lasti[u] = '0;
    if (clr[u]) begin
      for (int a = 0; a < 256; a++) mem[u][a] = '0;
    end
  endtask

  // apply a completed access to the model and check read data
  task automatic complete(int u, bit pi, bit we, logic [7:0] a,
                          logic [15:0] wd, logic [1:0] be);
    logic [15:0] exp;
    if (pi || !we) begin
      exp = mem[u][a];
      if (pi) begin
        check("i_rdata", 32'(i_rdata[u]), 32'(exp));
        lasti[u] = exp;
      end else begin
        check("d_rdata", 32'(d_rdata[u]), 32'(exp));
        lastd[u] = exp;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (be[k]) mem[u][a][8*k +: 8] = wd[8*k +: 8];
      end
    end
  endtask

  task automatic idle_checks(int u);
    cyc();
    check("ack_pulse", 32'(d_ack[u] | i_ack[u]), 0);
    check("d_rdata_hold", 32'(d_rdata[u]), 32'(lastd[u]));
    check("i_rdata_hold", 32'(i_rdata[u]), 32'(lasti[u]));
  endtask

  task automatic access(int u, bit pi, bit we, logic [7:0] a,
                        logic [15:0] wd, logic [1:0] be);
    int n;
    if (pi) begin
      i_req[u]  = 1'b1;
      i_addr[u] = a;
    end else begin
      d_req[u]   = 1'b1;
      d_we[u]    = we;
      d_addr[u]  = a;
      d_wdata[u] = wd;
      d_be[u]    = be;
    end
    n = 0;
    do begin
      cyc();
      n++;
    end while (!(pi ? i_ack[u] : d_ack[u]) && n < 40);
    check(pi ? "i_latency" : "d_latency", n, wt[u] + 1);
    check("other_ack", 32'(pi ? d_ack[u] : i_ack[u]), 0);
    complete(u, pi, we, a, wd, be);
    lastg[u] = pi;
    d_req[u] = 1'b0;
    i_req[u] = 1'b0;
    idle_checks(u);
  endtask

  // both ports request in the same cycle
  task automatic dual(int u, bit we, logic [7:0] da,
                      logic [15:0] wd, logic [1:0] be,
                      logic [7:0] ia);
    int n, nd, ni;
    bit first;
    first      = lastg[u] ? 1'b0 : 1'b1;
    d_req[u]   = 1'b1;
    d_we[u]    = we;
    d_addr[u]  = da;
    d_wdata[u] = wd;
    d_be[u]    = be;
    i_req[u]   = 1'b1;
    i_addr[u]  = ia;
    n  = 0;
    nd = -1;
    ni = -1;
    while ((nd < 0 || ni < 0) && n < 80) begin
      cyc();
      n++;
      if (d_ack[u] && nd < 0) begin
        nd = n;
        complete(u, 1'b0, we, da, wd, be);
        d_req[u] = 1'b0;
      end
      if (i_ack[u] && ni < 0) begin
        ni = n;
        complete(u, 1'b1, 1'b0, ia, '0, '0);
        i_req[u] = 1'b0;
      end
    end
    check("dual_d_ack_cycle", nd,
          first ? 2 * wt[u] + 3 : wt[u] + 1);
    check("dual_i_ack_cycle", ni,
          first ? wt[u] + 1 : 2 * wt[u] + 3);
    d_req[u] = 1'b0;
    i_req[u] = 1'b0;
    lastg[u] = ~first;
    idle_checks(u);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0]  a;
    logic [15:0] wd;
    for (int u = 0; u < 2; u++) begin
      rst[u]     = 1'b1;
      d_req[u]   = 1'b0;
      d_we[u]    = 1'b0;
      d_addr[u]  = '0;
      d_wdata[u] = '0;
      d_be[u]    = '0;
      i_req[u]   = 1'b0;
      i_addr[u]  = '0;
    end
    #3;
    do_reset(0);
    do_reset(1);

    access(0, 1'b1, 1'b0, 8'h00, '0, '0);
    access(0, 1'b0, 1'b0, 8'hFF, '0, '0);
    access(0, 1'b0, 1'b1, 8'h12, 16'hBEEF, 2'b11);
    access(0, 1'b0, 1'b0, 8'h12, '0, '0);
    access(0, 1'b0, 1'b1, 8'h12, 16'h1234, 2'b01);
    access(0, 1'b0, 1'b0, 8'h12, '0, '0);
    check("be01_value", 32'(lastd[0]), 32'h0000BE34);
    access(0, 1'b0, 1'b1, 8'h12, 16'h5678, 2'b00);
    access(0, 1'b1, 1'b0, 8'h12, '0, '0);
    check("be00_value", 32'(lasti[0]), 32'h0000BE34);

    repeat (4) dual(0, 1'b0, 8'h12, '0, '0, 8'h12);

    d_req[0]   = 1'b1;
    d_we[0]    = 1'b1;
    d_addr[0]  = 8'h20;
    d_wdata[0] = 16'hAAAA;
    d_be[0]    = 2'b11;
    cyc();
    cyc();
    check("abort_no_ack", 32'(d_ack[0]), 0);
    do_reset(0);
    access(0, 1'b0, 1'b0, 8'h20, '0, '0);
    check("abort_value", 32'(lastd[0]), 0);

    repeat (200) begin
      a  = ($urandom_range(0, 3) == 0) ? 8'($urandom)
                                        : 8'($urandom_range(16, 23));
      wd = 16'($urandom);
      case ($urandom_range(0, 3))
        0: access(0, 1'b0, 1'b1, a, wd, 2'($urandom));
        1: access(0, 1'b0, 1'b0, a, '0, '0);
        2: access(0, 1'b1, 1'b0, a, '0, '0);
        default: dual(0, 1'($urandom), a, wd, 2'($urandom),
                      8'($urandom_range(16, 23)));
      endcase
    end

    for (int k = 0; k < 4; k++) begin
      access(1, 1'b0, 1'b1, 8'(k), 16'($urandom), 2'b11);
    end
    for (int k = 0; k < 4; k++) begin
      access(1, 1'b1, 1'b0, 8'(k), '0, '0);
    end
    do_reset(1);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
